i2c_fifo_slave: RTL and testbench
=================================

// Module: i2c_fifo_slave
// PURPOSE
//  I2C slave (target) that drains the DSP->I2C FIFO onto the I2C bus. Sits directly
//  downstream of the FIFO: consumes its dout/doutV/cnt, pops via doutR. An external
//  master reads the FIFO fill count or streams FIFO data bytes. SCL/SDA are
//  oversampled in the clk domain; no clock stretching.
// PARAMETERS
//  SLAVE_ADDR  7'h42  7-bit I2C address this block answers to
//  CNTSIZE     8      width of fifo_cnt; must be <= 8, zero-extended to a byte
//  SYNC_STAGES 2      flops in the SCL/SDA input synchronisers (>= 2)
// PORTS
//  clk         in   1        system clock; must be >= 16x SCL frequency
//  reset       in   1        asynchronous, active-low reset
//  scl_i       in   1        I2C SCL pad input (asynchronous)
//  sda_i       in   1        I2C SDA pad input (asynchronous)
//  sda_oe      out  1        1 = pull SDA low (open-drain), 0 = release
//  fifo_dout   in   8        FIFO head byte
//  fifo_doutV  in   1        FIFO head valid (FIFO not empty)
//  fifo_doutR  out  1        one-clk pop strobe to FIFO
//  fifo_cnt    in   CNTSIZE  FIFO entry count
//  busy        out  1        1 whenever state != IDLE
// BEHAVIOUR
//  - Reset (reset=0, async): sda_oe=0, fifo_doutR=0, busy=0, state=IDLE, ptr=1,
//    shift/bit counters=0, synchronisers preset to 1 (idle bus).
//  - Inputs pass SYNC_STAGES flops + 1 edge-detect flop; SCL rise/fall, START
//    (SDA fall while SCL=1), STOP (SDA rise while SCL=1) are one-clk pulses.
//  - START from any state -> ADDR, bit counter cleared (repeated START included).
//    STOP from any state -> IDLE, sda_oe=0 on the next clk.
//  - States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, TX, TX_ACK, WAIT_STOP.
//  - ADDR: shift 8 bits MSB-first on SCL rise. Addr match -> ADDR_ACK (drive SDA low
//    from next SCL fall to following SCL fall); no match -> WAIT_STOP, SDA untouched.
//  - R/W=0: PTR receives 1 byte. 0x00 or 0x01 -> ptr updated, ACK, then WAIT_STOP
//    (further written bytes NACKed). Any other value -> NACK, ptr unchanged.
//  - R/W=1: at SCL fall ending ADDR_ACK, load tx byte, enter TX; MSB driven from this
//    fall. sda_oe = ~tx_bit, updated 1 clk after each detected SCL fall.
//  - Tx byte source: ptr=0 -> {zero-extend fifo_cnt} sampled at load.
//    ptr=1 -> fifo_dout if fifo_doutV=1, and fifo_doutR=1 for exactly that load clk;
//    ptr=1 and fifo_doutV=0 -> byte 0x00, no pop.
//  - After 8 bits: TX_ACK releases SDA and samples master bit on SCL rise.
//    ACK(0) -> load next byte at next SCL fall (same pop rule), back to TX.
//    NACK(1) -> WAIT_STOP, SDA released, no further load or pop.
//  - At most one pop per transmitted byte; never pop when fifo_doutV=0. A popped byte
//    is considered consumed even if the master subsequently NACKs it.
//  - ptr persists across transactions; only reset returns it to 1.
//  - Reset mid-transfer: SDA released immediately (async); a half-sent byte is
//    lost if it had already been popped.
// TESTING
//  1. reset low mid TX byte -> sda_oe=0, fifo_doutR=0, busy=0 same cycle; ptr=1.
//  2. Write 0x84 (addr 0x42,W) + 0x00, STOP; read 0x85 -> ACKs, byte read = fifo_cnt
//     (cnt=5 -> 0x05), no fifo_doutR pulse.
//  3. FIFO holds A5,3C,F0; read 0x85, ACK,ACK,NACK -> bytes A5,3C,F0; exactly 3
//     single-clk fifo_doutR pulses; none after NACK.
//  4. FIFO empty, ptr=1, read 2 bytes -> 0x00,0x00, fifo_doutR never asserted.
//  5. Address 0x43 (R) -> no ACK (sda_oe stays 0 whole txn), no pop, busy until STOP.
//  6. Write ptr 0x07 -> NACK, ptr unchanged; repeated START mid-read -> ADDR re-entered,
//     next read ACKed and served normally.

Source files
------------

// File: rtl/i2c_fifo_slave.sv
// i2c_fifo_slave: I2C target that drains the DSP->I2C FIFO onto the bus.
// The master either reads the FIFO fill count (ptr=0) or streams FIFO data
// bytes (ptr=1). SCL/SDA are oversampled in the clk domain, no clock stretching.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | bus free, SDA released
// ADDR      | shifting in address byte + R/W bit
// ADDR_ACK  | address matched, driving ACK for one SCL low-high-low window
// PTR       | receiving pointer byte (write transaction)
// PTR_ACK   | ACK (ptr 0x00/0x01) or NACK (anything else) for pointer byte
// TX        | shifting a byte out MSB-first, SDA updated after each SCL fall
// TX_ACK    | SDA released, sampling the master's ACK/NACK on SCL rise
// WAIT_STOP | ignoring the bus until STOP or repeated START

module i2c_fifo_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         CNTSIZE     = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               scl_i,
    input  logic               sda_i,
    output logic               sda_oe,
    input  logic [7:0]         fifo_dout,
    input  logic               fifo_doutV,
    output logic               fifo_doutR,
    input  logic [CNTSIZE-1:0] fifo_cnt,
    output logic               busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, TX, TX_ACK, WAIT_STOP
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;
    logic [6:0]             shift;
    logic [7:0]             rx_byte;
    logic [2:0]             bit_cnt;
    logic [6:0]             tx_shift;
    logic                   ack_phase;
    logic                   rw;
    logic                   ptr;
    logic                   ptr_ok;
    logic [7:0]             cnt_byte;
    logic [7:0]             load_byte;
    logic                   load_pop;

    // Synchronise the pads; the extra edge-detect flop gives one-clk event pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign rx_byte   = {shift, sda_s};
    assign cnt_byte  = 8'(fifo_cnt);
    assign busy      = (state != IDLE);

    // Select the next transmit byte; only a valid FIFO head is ever popped
    always_comb begin
        load_byte = 8'h00;
        load_pop  = 1'b0;
        if (!ptr) begin
            load_byte = cnt_byte;
        end else if (fifo_doutV) begin
            load_byte = fifo_dout;
            load_pop  = 1'b1;
        end
    end

    // Protocol FSM with registered SDA drive and pop strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sda_oe     <= 1'b0;
            fifo_doutR <= 1'b0;
            ptr        <= 1'b1;
            shift      <= '0;
            bit_cnt    <= '0;
            tx_shift   <= '0;
            ack_phase  <= 1'b0;
            rw         <= 1'b0;
            ptr_ok     <= 1'b0;
        end else begin
            fifo_doutR <= 1'b0;
            if (start_det) begin
                state     <= ADDR;
                bit_cnt   <= '0;
                sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
            end else if (stop_det) begin
                state     <= IDLE;
                sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ack_phase <= 1'b0;
                                rw        <= rx_byte[0];
                                state     <= (rx_byte[7:1] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oe    <= 1'b1;
                                ack_phase <= 1'b1;
                            end else begin
                                ack_phase <= 1'b0;
                                bit_cnt   <= '0;
                                if (rw) begin
                                    tx_shift   <= load_byte[6:0];
                                    sda_oe     <= ~load_byte[7];
                                    fifo_doutR <= load_pop;
                                    state      <= TX;
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= PTR;
                                end
                            end
                        end
                    end
                    PTR: begin
                        if (scl_rise) begin
                            shift   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ptr_ok <= (rx_byte[7:1] == 7'd0);
                                if (rx_byte[7:1] == 7'd0)
                                    ptr <= rx_byte[0];
                                ack_phase <= 1'b0;
                                state     <= PTR_ACK;
                            end
                        end
                    end
                    PTR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oe    <= ptr_ok;
                                ack_phase <= 1'b1;
                            end else begin
                                sda_oe    <= 1'b0;
                                ack_phase <= 1'b0;
                                state     <= WAIT_STOP;
                            end
                        end
                    end
                    TX: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe    <= 1'b0;
                                ack_phase <= 1'b0;
                                state     <= TX_ACK;
                            end else begin
                                sda_oe   <= ~tx_shift[6];
                                tx_shift <= {tx_shift[5:0], 1'b0};
                                bit_cnt  <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise) begin
                            if (sda_s)
                                state <= WAIT_STOP;
                            else
                                ack_phase <= 1'b1;
                        end else if (scl_fall && ack_phase) begin
                            ack_phase  <= 1'b0;
                            bit_cnt    <= '0;
                            tx_shift   <= load_byte[6:0];
                            sda_oe     <= ~load_byte[7];
                            fifo_doutR <= load_pop;
                            state      <= TX;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_fifo_slave.sv
// Directed bench for i2c_fifo_slave: bit-banged I2C master plus a FIFO model.
module tb_i2c_fifo_slave;

    localparam int H = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic       fifo_doutR;
    logic       busy;
    logic [7:0] fifo_dout;
    logic       fifo_doutV;
    logic [7:0] fifo_cnt;

    logic [7:0] mem [256];
    logic [7:0] rd = 8'd0;
    logic [7:0] wr = 8'd0;
    int         pops = 0;
    int         bad_pops = 0;
    int         dbl_pops = 0;
    int         oe_clks = 0;
    logic       prev_r = 1'b0;

    int tests = 0;
    int fails = 0;

    assign scl_i      = scl_m;
    assign sda_i      = sda_m & ~sda_oe;
    assign fifo_dout  = mem[rd];
    assign fifo_doutV = (rd != wr);
    assign fifo_cnt   = wr - rd;

    always #5 clk = ~clk;

    i2c_fifo_slave #(.SLAVE_ADDR(7'h42), .CNTSIZE(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
        .fifo_dout(fifo_dout), .fifo_doutV(fifo_doutV), .fifo_doutR(fifo_doutR),
        .fifo_cnt(fifo_cnt), .busy(busy)
    );

    // FIFO model: pop on strobe, flag pops from empty and multi-clk strobes
    always @(posedge clk) begin
        prev_r <= fifo_doutR;
        if (fifo_doutR) begin
            pops <= pops + 1;
            if (prev_r) dbl_pops <= dbl_pops + 1;
            if (rd == wr) bad_pops <= bad_pops + 1;
            else rd <= rd + 8'd1;
        end
        if (sda_oe) oe_clks <= oe_clks + 1;
    end

    task automatic hw(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fifo_push(input logic [7:0] d);
        mem[wr] = d;
        wr = wr + 8'd1;
    endtask

    task automatic fifo_clear();
        wr = rd;
    endtask

    task automatic i2c_start();
        hw(4); sda_m = 1'b1; hw(H);
        scl_m = 1'b1; hw(H);
        sda_m = 1'b0; hw(H);
        scl_m = 1'b0; hw(H);
    endtask

    task automatic i2c_stop();
        hw(4); sda_m = 1'b0; hw(H);
        scl_m = 1'b1; hw(H);
        sda_m = 1'b1; hw(H);
    endtask

    task automatic write_bit(input logic b);
        hw(4); sda_m = b; hw(H - 4);
        scl_m = 1'b1; hw(H);
        scl_m = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        hw(4); sda_m = 1'b1; hw(H - 4);
        scl_m = 1'b1; hw(H / 2);
        b = sda_i; hw(H / 2);
        scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack);
    endtask

    task automatic test_reset();
        hw(5);
        tests++;
        if ({sda_oe, fifo_doutR, busy} !== 3'b000) begin
            fails++;
            $display("FAIL reset_outputs: got oe/pop/busy=%b want 000", {sda_oe, fifo_doutR, busy});
        end
        reset = 1'b1;
        hw(10);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_ptr_cnt();
        logic a;
        logic [7:0] d;
        int p0;
        for (int i = 1; i <= 5; i++) fifo_push(8'(i * 8'h11));
        i2c_start();
        write_byte(8'h84, a);
        tests++;
        if (a !== 1'b0) begin fails++; $display("FAIL ptr_addr_ack: got %b want 0", a); end
        write_byte(8'h00, a);
        tests++;
        if (a !== 1'b0) begin fails++; $display("FAIL ptr0_ack: got %b want 0", a); end
        write_byte(8'h01, a);
        tests++;
        if (a !== 1'b1) begin fails++; $display("FAIL extra_write_nack: got %b want 1", a); end
        i2c_stop();
        p0 = pops;
        i2c_start();
        write_byte(8'h85, a);
        tests++;
        if (a !== 1'b0) begin fails++; $display("FAIL cnt_read_addr_ack: got %b want 0", a); end
        read_byte(d, 1'b1);
        i2c_stop();
        hw(5);
        tests++;
        if (d !== 8'h05) begin fails++; $display("FAIL cnt_byte: got %h want 05", d); end
        tests++;
        if (pops !== p0) begin fails++; $display("FAIL cnt_no_pop: got %0d pops want 0", pops - p0); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL cnt_busy_after_stop: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic a;
        logic b;
        logic [7:0] d;
        int p0;
        i2c_start();
        write_byte(8'h85, a);
        for (int i = 0; i < 3; i++) read_bit(b);
        hw(10);
        tests++;
        if ({sda_oe, busy} !== 2'b11) begin
            fails++;
            $display("FAIL mid_tx_drive: got oe/busy=%b want 11", {sda_oe, busy});
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({sda_oe, fifo_doutR, busy} !== 3'b000) begin
            fails++;
            $display("FAIL async_reset_outputs: got oe/pop/busy=%b want 000", {sda_oe, fifo_doutR, busy});
        end
        scl_m = 1'b1;
        sda_m = 1'b1;
        hw(10);
        reset = 1'b1;
        hw(10);
        p0 = pops;
        i2c_start();
        write_byte(8'h85, a);
        read_byte(d, 1'b1);
        i2c_stop();
        hw(5);
        tests++;
        if (d !== 8'h11) begin fails++; $display("FAIL reset_ptr_is_1: got %h want 11", d); end
        tests++;
        if (pops - p0 !== 1) begin fails++; $display("FAIL reset_ptr_pop: got %0d pops want 1", pops - p0); end
    endtask

    task automatic test_stream();
        logic a;
        logic [7:0] d0, d1, d2;
        int p0;
        int b0;
        int dbl0;
        fifo_clear();
        fifo_push(8'hA5); fifo_push(8'h3C); fifo_push(8'hF0); fifo_push(8'h77);
        p0 = pops; b0 = bad_pops; dbl0 = dbl_pops;
        i2c_start();
        write_byte(8'h85, a);
        read_byte(d0, 1'b0);
        read_byte(d1, 1'b0);
        read_byte(d2, 1'b1);
        i2c_stop();
        hw(10);
        tests++;
        if ({d0, d1, d2} !== 24'hA53CF0) begin
            fails++;
            $display("FAIL stream_bytes: got %h %h %h want a5 3c f0", d0, d1, d2);
        end
        tests++;
        if (pops - p0 !== 3) begin fails++; $display("FAIL stream_pops: got %0d want 3", pops - p0); end
        tests++;
        if (dbl_pops !== dbl0) begin fails++; $display("FAIL stream_pulse_width: got %0d long pulses want 0", dbl_pops - dbl0); end
        tests++;
        if (fifo_cnt !== 8'd1) begin fails++; $display("FAIL stream_left_in_fifo: got %0d want 1", fifo_cnt); end
        tests++;
        if (bad_pops !== b0) begin fails++; $display("FAIL stream_empty_pop: got %0d want 0", bad_pops - b0); end
    endtask

    task automatic test_empty();
        logic a;
        logic [7:0] d0, d1;
        int p0;
        fifo_clear();
        p0 = pops;
        i2c_start();
        write_byte(8'h85, a);
        read_byte(d0, 1'b0);
        read_byte(d1, 1'b1);
        i2c_stop();
        hw(5);
        tests++;
        if ({d0, d1} !== 16'h0000) begin fails++; $display("FAIL empty_bytes: got %h %h want 00 00", d0, d1); end
        tests++;
        if (pops !== p0) begin fails++; $display("FAIL empty_no_pop: got %0d pops want 0", pops - p0); end
    endtask

    task automatic test_bad_addr();
        logic a;
        logic [7:0] d;
        int p0;
        int oe0;
        fifo_push(8'h5A);
        p0 = pops;
        oe0 = oe_clks;
        i2c_start();
        write_byte(8'h87, a);
        tests++;
        if (a !== 1'b1) begin fails++; $display("FAIL bad_addr_nack: got %b want 1", a); end
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL bad_addr_busy: got %b want 1", busy); end
        read_byte(d, 1'b1);
        tests++;
        if (d !== 8'hFF) begin fails++; $display("FAIL bad_addr_bus_free: got %h want ff", d); end
        i2c_stop();
        hw(5);
        tests++;
        if (oe_clks !== oe0) begin fails++; $display("FAIL bad_addr_sda_driven: got %0d clks want 0", oe_clks - oe0); end
        tests++;
        if (pops !== p0) begin fails++; $display("FAIL bad_addr_pop: got %0d want 0", pops - p0); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL bad_addr_busy_after_stop: got %b want 0", busy); end
    endtask

    task automatic test_bad_ptr_rstart();
        logic a;
        logic [7:0] d;
        int p0;
        i2c_start();
        write_byte(8'h84, a);
        write_byte(8'h00, a);
        i2c_stop();
        i2c_start();
        write_byte(8'h84, a);
        write_byte(8'h07, a);
        tests++;
        if (a !== 1'b1) begin fails++; $display("FAIL bad_ptr_nack: got %b want 1", a); end
        i2c_stop();
        p0 = pops;
        i2c_start();
        write_byte(8'h85, a);
        read_byte(d, 1'b1);
        tests++;
        if (d !== 8'h01) begin fails++; $display("FAIL bad_ptr_unchanged: got %h want 01", d); end
        i2c_start();
        write_byte(8'h85, a);
        tests++;
        if (a !== 1'b0) begin fails++; $display("FAIL rstart_addr_ack: got %b want 0", a); end
        read_byte(d, 1'b1);
        i2c_stop();
        hw(5);
        tests++;
        if (d !== 8'h01) begin fails++; $display("FAIL rstart_byte: got %h want 01", d); end
        tests++;
        if (pops !== p0) begin fails++; $display("FAIL rstart_no_pop: got %0d want 0", pops - p0); end
        i2c_start();
        write_byte(8'h84, a);
        write_byte(8'h01, a);
        i2c_stop();
        i2c_start();
        write_byte(8'h85, a);
        read_byte(d, 1'b1);
        i2c_stop();
        hw(5);
        tests++;
        if (d !== 8'h5A || pops - p0 !== 1) begin
            fails++;
            $display("FAIL ptr1_after_rstart: got %h with %0d pops want 5a with 1", d, pops - p0);
        end
    endtask

    initial begin
        test_reset();
        test_ptr_cnt();
        test_reset_mid();
        test_stream();
        test_empty();
        test_bad_addr();
        test_bad_ptr_rstart();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
